// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared state type, width helpers and parameter checks for the fetch controller
package pc_fetch_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, HALT, ERR} state_t;

    function automatic int step_of(input int inst_w);
        return inst_w / 8;
    endfunction

    function automatic int align_of(input int inst_w);
        return inst_w == 64 ? 3 : inst_w == 32 ? 2 : inst_w == 16 ? 1 : 0;
    endfunction

    function automatic bit params_ok(input int addr_w, input int inst_w, input logic [63:0] reset_vec);
        return (inst_w == 8 || inst_w == 16 || inst_w == 32 || inst_w == 64)
            && addr_w > align_of(inst_w)
            && (reset_vec & 64'(step_of(inst_w) - 1)) == 64'd0;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-state / next-PC selection and output-latch controls
module pc_next_sel
    import pc_fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  state_t            state,
    input  logic [ADDR_W-1:0] pc,
    input  logic              stall,
    input  logic              branch,
    input  logic [ADDR_W-1:0] target,
    input  logic              halt,
    input  logic              ack,
    output logic              req,
    output state_t            state_d,
    output logic [ADDR_W-1:0] pc_d,
    output logic              accept,
    output logic              clr_valid,
    output logic              set_misalign
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(step_of(INST_W));
    localparam logic [ADDR_W-1:0] MASK = ADDR_W'(step_of(INST_W) - 1);

    logic live;
    logic misaligned;

    // ERR freezes everything; branch beats halt beats stall beats ack
    always_comb begin
        live = state != ERR;
        misaligned = (target & MASK) != '0;
        req = state == FETCH && !stall;
        accept = req && ack && !branch && !halt;
        set_misalign = live && branch && misaligned;
        clr_valid = (live && (branch || halt)) || (req && !ack);
        pc_d = !live ? pc : (branch && !misaligned) ? target : accept ? pc + STEP : pc;
        state_d = !live ? ERR
                : branch ? (misaligned ? ERR : FETCH)
                : halt ? HALT
                : state == IDLE ? FETCH
                : state;
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter and request/ack instruction-fetch front end of the pipeline
module pc_fetch_ctrl
    import pc_fetch_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                INST_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_stall,
    input  logic              i_branch,
    input  logic [ADDR_W-1:0] i_target,
    input  logic              i_halt,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [INST_W-1:0] i_imem_data,
    output logic [INST_W-1:0] o_inst,
    output logic [ADDR_W-1:0] o_inst_pc,
    output logic              o_inst_valid,
    output logic              o_misalign
);

    if (!params_ok(ADDR_W, INST_W, 64'(RESET_VEC))) begin : g_bad_params
        $error("pc_fetch_ctrl: illegal ADDR_W/INST_W/RESET_VEC combination");
    end

    state_t            state;
    state_t            state_d;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_d;
    logic              accept;
    logic              clr_valid;
    logic              set_misalign;

    pc_next_sel #(
        .ADDR_W(ADDR_W),
        .INST_W(INST_W)
    ) u_next_sel (
        .state       (state),
        .pc          (pc),
        .stall       (i_stall),
        .branch      (i_branch),
        .target      (i_target),
        .halt        (i_halt),
        .ack         (i_imem_ack),
        .req         (o_imem_req),
        .state_d     (state_d),
        .pc_d        (pc_d),
        .accept      (accept),
        .clr_valid   (clr_valid),
        .set_misalign(set_misalign)
    );

    assign o_imem_addr = pc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            pc           <= RESET_VEC;
            o_inst       <= '0;
            o_inst_pc    <= '0;
            o_inst_valid <= 1'b0;
            o_misalign   <= 1'b0;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            if (accept) begin
                o_inst    <= i_imem_data;
                o_inst_pc <= pc;
            end
            o_inst_valid <= accept | (o_inst_valid & ~clr_valid);
            o_misalign   <= o_misalign | set_misalign;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: vector tables, reset corner case and a randomized run against a reference model
module tb_pc_fetch_ctrl;

    typedef struct {
        logic        stall;
        logic        br;
        logic        halt;
        logic        ack;
        logic [31:0] tgt;
        logic [31:0] data;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_ipc;
        logic [31:0] e_inst;
        logic        e_mis;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_stall = 0, a_branch = 0, a_halt = 0, a_ack = 0;
    logic [31:0] a_target = 0, a_data = 0;
    logic        a_req, a_valid, a_mis;
    logic [31:0] a_addr, a_inst, a_ipc;

    logic        b_stall = 0, b_branch = 0, b_halt = 0, b_ack = 0;
    logic [7:0]  b_target = 0;
    logic [15:0] b_data = 0;
    logic        b_req, b_valid, b_mis;
    logic [7:0]  b_addr, b_ipc;
    logic [15:0] b_inst;

    pc_fetch_ctrl #(.ADDR_W(32), .INST_W(32), .RESET_VEC(32'h100)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_stall(a_stall), .i_branch(a_branch), .i_target(a_target),
        .i_halt(a_halt), .o_imem_req(a_req), .o_imem_addr(a_addr), .i_imem_ack(a_ack),
        .i_imem_data(a_data), .o_inst(a_inst), .o_inst_pc(a_ipc), .o_inst_valid(a_valid),
        .o_misalign(a_mis)
    );

    pc_fetch_ctrl #(.ADDR_W(8), .INST_W(16), .RESET_VEC(8'hFC)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_stall(b_stall), .i_branch(b_branch), .i_target(b_target),
        .i_halt(b_halt), .o_imem_req(b_req), .o_imem_addr(b_addr), .i_imem_ack(b_ack),
        .i_imem_data(b_data), .o_inst(b_inst), .o_inst_pc(b_ipc), .o_inst_valid(b_valid),
        .o_misalign(b_mis)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // reference model of dut_a (32-bit address, 4-byte instructions, reset vector 0x100)
    localparam int M_IDLE = 0, M_FETCH = 1, M_HALT = 2, M_ERR = 3;
    int          m_mode;
    logic [31:0] m_pc, m_inst, m_ipc;
    logic        m_valid, m_mis;

    task automatic m_reset();
        m_mode = M_IDLE;
        m_pc = 32'h100;
        m_inst = 0;
        m_ipc = 0;
        m_valid = 0;
        m_mis = 0;
    endtask

    task automatic m_step(input logic s, br, h, ak, input logic [31:0] tgt, dat);
        if (m_mode == M_ERR) return;
        if (br) begin
            m_valid = 0;
            if (tgt % 4 != 0) begin
                m_mis = 1;
                m_mode = M_ERR;
            end else begin
                m_pc = tgt;
                m_mode = M_FETCH;
            end
        end else if (h) begin
            m_mode = M_HALT;
            m_valid = 0;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_FETCH;
        end else if (m_mode == M_FETCH && !s) begin
            if (ak) begin
                m_inst = dat;
                m_ipc = m_pc;
                m_valid = 1;
                m_pc = m_pc + 32'd4;
            end else begin
                m_valid = 0;
            end
        end
    endtask

    task automatic drive(input bit sel, input logic s, br, h, ak, input logic [31:0] tgt, dat);
        a_stall = 0; a_branch = 0; a_halt = 0; a_ack = 0; a_target = 0; a_data = 0;
        b_stall = 0; b_branch = 0; b_halt = 0; b_ack = 0; b_target = 0; b_data = 0;
        if (sel) begin
            b_stall = s; b_branch = br; b_halt = h; b_ack = ak; b_target = tgt[7:0]; b_data = dat[15:0];
        end else begin
            a_stall = s; a_branch = br; a_halt = h; a_ack = ak; a_target = tgt; a_data = dat;
        end
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1;
        m_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic apply_vec(input bit sel, input vec_t v, input int idx);
        drive(sel, v.stall, v.br, v.halt, v.ack, v.tgt, v.data);
        #1;
        chk($sformatf("t%0d[%0d] req", sel, idx), sel ? 64'(b_req) : 64'(a_req), 64'(v.e_req));
        chk($sformatf("t%0d[%0d] addr", sel, idx), sel ? 64'(b_addr) : 64'(a_addr), 64'(v.e_addr));
        @(posedge clk);
        #1;
        chk($sformatf("t%0d[%0d] valid", sel, idx), sel ? 64'(b_valid) : 64'(a_valid), 64'(v.e_valid));
        chk($sformatf("t%0d[%0d] inst_pc", sel, idx), sel ? 64'(b_ipc) : 64'(a_ipc), 64'(v.e_ipc));
        chk($sformatf("t%0d[%0d] inst", sel, idx), sel ? 64'(b_inst) : 64'(a_inst), 64'(v.e_inst));
        chk($sformatf("t%0d[%0d] misalign", sel, idx), sel ? 64'(b_mis) : 64'(a_mis), 64'(v.e_mis));
        @(negedge clk);
    endtask

    initial begin
        vec_t ta[19];
        vec_t tb[11];
        // stall, br, halt, ack, tgt, data | req, addr, valid, inst_pc, inst, misalign
        ta = '{
            '{0, 0, 0, 1, 32'h0,    32'hAA,   0, 32'h100,  0, 32'h0,    32'h0,    0},
            '{0, 0, 0, 1, 32'h0,    32'hD0,   1, 32'h100,  1, 32'h100,  32'hD0,   0},
            '{0, 0, 0, 1, 32'h0,    32'hD1,   1, 32'h104,  1, 32'h104,  32'hD1,   0},
            '{0, 0, 0, 1, 32'h0,    32'hD2,   1, 32'h108,  1, 32'h108,  32'hD2,   0},
            '{1, 0, 0, 1, 32'h0,    32'hEE,   0, 32'h10C,  1, 32'h108,  32'hD2,   0},
            '{1, 0, 0, 1, 32'h0,    32'hEE,   0, 32'h10C,  1, 32'h108,  32'hD2,   0},
            '{1, 0, 0, 1, 32'h0,    32'hEE,   0, 32'h10C,  1, 32'h108,  32'hD2,   0},
            '{0, 0, 0, 0, 32'h0,    32'h0,    1, 32'h10C,  0, 32'h108,  32'hD2,   0},
            '{0, 0, 0, 1, 32'h0,    32'hD3,   1, 32'h10C,  1, 32'h10C,  32'hD3,   0},
            '{0, 1, 0, 1, 32'h2000, 32'hBB,   1, 32'h110,  0, 32'h10C,  32'hD3,   0},
            '{0, 0, 0, 1, 32'h0,    32'hD4,   1, 32'h2000, 1, 32'h2000, 32'hD4,   0},
            '{0, 0, 1, 1, 32'h0,    32'hCC,   1, 32'h2004, 0, 32'h2000, 32'hD4,   0},
            '{0, 0, 0, 1, 32'h0,    32'hCD,   0, 32'h2004, 0, 32'h2000, 32'hD4,   0},
            '{0, 0, 0, 0, 32'h0,    32'h0,    0, 32'h2004, 0, 32'h2000, 32'hD4,   0},
            '{0, 1, 0, 0, 32'h40,   32'h0,    0, 32'h2004, 0, 32'h2000, 32'hD4,   0},
            '{0, 0, 0, 1, 32'h0,    32'hD5,   1, 32'h40,   1, 32'h40,   32'hD5,   0},
            '{0, 1, 0, 1, 32'h2002, 32'h99,   1, 32'h44,   0, 32'h40,   32'hD5,   1},
            '{0, 1, 0, 1, 32'h3000, 32'h98,   0, 32'h44,   0, 32'h40,   32'hD5,   1},
            '{0, 0, 0, 1, 32'h0,    32'h97,   0, 32'h44,   0, 32'h40,   32'hD5,   1}
        };
        tb = '{
            '{0, 0, 0, 1, 32'h0,  32'hAAAA, 0, 32'hFC, 0, 32'h0,  32'h0,    0},
            '{0, 0, 0, 1, 32'h0,  32'h1111, 1, 32'hFC, 1, 32'hFC, 32'h1111, 0},
            '{0, 0, 0, 1, 32'h0,  32'h2222, 1, 32'hFE, 1, 32'hFE, 32'h2222, 0},
            '{0, 0, 0, 1, 32'h0,  32'h3333, 1, 32'h00, 1, 32'h00, 32'h3333, 0},
            '{0, 0, 1, 1, 32'h0,  32'h4444, 1, 32'h02, 0, 32'h00, 32'h3333, 0},
            '{0, 0, 0, 1, 32'h0,  32'h5555, 0, 32'h02, 0, 32'h00, 32'h3333, 0},
            '{0, 1, 0, 0, 32'h40, 32'h0,    0, 32'h02, 0, 32'h00, 32'h3333, 0},
            '{0, 0, 0, 1, 32'h0,  32'h6666, 1, 32'h40, 1, 32'h40, 32'h6666, 0},
            '{0, 0, 0, 1, 32'h0,  32'h7777, 1, 32'h42, 1, 32'h42, 32'h7777, 0},
            '{0, 1, 0, 1, 32'h41, 32'h8888, 1, 32'h44, 0, 32'h42, 32'h7777, 1},
            '{0, 1, 0, 1, 32'h40, 32'h9999, 0, 32'h44, 0, 32'h42, 32'h7777, 1}
        };

        do_reset();
        foreach (ta[i]) apply_vec(0, ta[i], i);

        // dut_a now sits in ERR; reset must clear it without waiting for a clock edge
        rst = 1;
        #1;
        chk("async rst req", 64'(a_req), 64'(0));
        chk("async rst addr", 64'(a_addr), 64'(32'h100));
        chk("async rst misalign", 64'(a_mis), 64'(0));
        chk("async rst inst_pc", 64'(a_ipc), 64'(0));
        chk("async rst inst", 64'(a_inst), 64'(0));
        chk("async rst valid", 64'(a_valid), 64'(0));

        do_reset();
        foreach (tb[i]) apply_vec(1, tb[i], i);

        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic        s, br, h, ak;
            logic [31:0] tgt, dat;
            if ($urandom_range(99) < 2) begin
                do_reset();
                continue;
            end
            s = $urandom_range(3) == 0;
            br = $urandom_range(11) == 0;
            h = $urandom_range(19) == 0;
            ak = $urandom_range(2) != 0;
            dat = $urandom;
            tgt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(9) == 0) tgt[1:0] = 2'($urandom_range(3, 1));
            if ($urandom_range(9) == 0) tgt = 32'hFFFF_FFF8;
            drive(0, s, br, h, ak, tgt, dat);
            #1;
            chk("rnd req", 64'(a_req), 64'(m_mode == M_FETCH && !s));
            chk("rnd addr", 64'(a_addr), 64'(m_pc));
            m_step(s, br, h, ak, tgt, dat);
            @(posedge clk);
            #1;
            chk("rnd valid", 64'(a_valid), 64'(m_valid));
            chk("rnd inst_pc", 64'(a_ipc), 64'(m_ipc));
            chk("rnd inst", 64'(a_inst), 64'(m_inst));
            chk("rnd misalign", 64'(a_mis), 64'(m_mis));
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
